// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC sine/cosine sequencer.
// All angles and vector components are signed Q2.30.
package cordic_pkg;

    localparam int unsigned Q_W = 32;

    localparam logic [Q_W-1:0] CORDIC_K     = 32'h26DD3B6A;
    localparam logic [Q_W-1:0] HALF_PI      = 32'h6487ED51;
    localparam logic [Q_W-1:0] NEG_HALF_PI  = 32'h9B7812AF;

    // atan(2^-i) in Q2.30, rounded to nearest
    localparam logic [Q_W-1:0] ATAN_LUT [0:31] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
    };

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    typedef struct packed {
        logic           sat;
        logic [Q_W-1:0] angle;
    } sat_angle_t;

    function automatic sat_angle_t saturate_angle(input logic [Q_W-1:0] a);
        sat_angle_t r;
        r.sat   = 1'b1;
        r.angle = a;
        if ($signed(a) > $signed(HALF_PI)) begin
            r.angle = HALF_PI;
        end else if ($signed(a) < $signed(NEG_HALF_PI)) begin
            r.angle = NEG_HALF_PI;
        end else begin
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_sequencer_if.sv
// Request/result handshake bundle between angle producers, the sequencer
// and result consumers.
interface cordic_sequencer_if;
    import cordic_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [Q_W-1:0] in_angle;
    logic           out_valid;
    logic           out_ready;
    logic [Q_W-1:0] out_cos;
    logic [Q_W-1:0] out_sin;
    logic           out_sat;
    logic           busy;

    modport master (
        output in_valid, in_angle, out_ready,
        input  in_ready, out_valid, out_cos, out_sin, out_sat, busy
    );

    modport slave (
        input  in_valid, in_angle, out_ready,
        output in_ready, out_valid, out_cos, out_sin, out_sat, busy
    );

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational iteration-index to arctangent-constant lookup.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [4:0]     i_idx,
    output logic [Q_W-1:0] o_atan
);

    assign o_atan = ATAN_LUT[i_idx];

endmodule

// File: rtl/cordic_update.sv
// Single CORDIC micro-rotation stage with registered outputs and no reset.
// Rotation sense leaves y holding the negated sine.
module cordic_update
    import cordic_pkg::*;
(
    input  logic                  clk,
    input  logic signed [Q_W-1:0] x,
    input  logic signed [Q_W-1:0] y,
    input  logic signed [Q_W-1:0] currentAngle,
    input  logic signed [Q_W-1:0] wantedAngle,
    input  logic [4:0]            iterate,
    input  logic [Q_W-1:0]        atan,
    output logic signed [Q_W-1:0] nx,
    output logic signed [Q_W-1:0] ny,
    output logic signed [Q_W-1:0] nangle
);

    logic                  w_dir_pos;
    logic signed [Q_W-1:0] w_x_sh;
    logic signed [Q_W-1:0] w_y_sh;

    assign w_dir_pos = (wantedAngle >= currentAngle);
    assign w_x_sh    = x >>> iterate;
    assign w_y_sh    = y >>> iterate;

    always_ff @(posedge clk) begin
        if (w_dir_pos) begin
            nx     <= x + w_y_sh;
            ny     <= y - w_x_sh;
            nangle <= currentAngle + $signed(atan);
        end else begin
            nx     <= x - w_y_sh;
            ny     <= y + w_x_sh;
            nangle <= currentAngle - $signed(atan);
        end
    end

endmodule

// File: rtl/cordic_sequencer.sv
// Iterative cos/sin controller: one request at a time is rotated through a
// single cordic_update stage for ITER cycles, then the vector is latched.
module cordic_sequencer
    import cordic_pkg::*;
#(
    parameter int unsigned ITER = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    cordic_sequencer_if.slave        bus
);

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    state_e         r_state;
    logic [4:0]     r_iter;
    logic [Q_W-1:0] r_angle;
    logic           r_sat_q;
    logic [Q_W-1:0] r_cos;
    logic [Q_W-1:0] r_sin;
    logic           r_out_sat;

    logic [Q_W-1:0] w_atan;
    logic [Q_W-1:0] w_stage_x;
    logic [Q_W-1:0] w_stage_y;
    logic [Q_W-1:0] w_stage_ang;
    logic [Q_W-1:0] w_nx;
    logic [Q_W-1:0] w_ny;
    logic [Q_W-1:0] w_nangle;
    sat_angle_t     w_sat;
    logic           w_accept;

    assign w_sat    = saturate_angle(bus.in_angle);
    assign w_accept = bus.in_valid && bus.in_ready;

    // Iteration 0 seeds the stage with the pre-scaled unit vector
    assign w_stage_x   = (r_iter == 5'd0) ? CORDIC_K : w_nx;
    assign w_stage_y   = (r_iter == 5'd0) ? '0       : w_ny;
    assign w_stage_ang = (r_iter == 5'd0) ? '0       : w_nangle;

    cordic_atan_rom u_atan_rom (
        .i_idx  (r_iter),
        .o_atan (w_atan)
    );

    cordic_update u_update (
        .clk          (clk),
        .x            (w_stage_x),
        .y            (w_stage_y),
        .currentAngle (w_stage_ang),
        .wantedAngle  (r_angle),
        .iterate      (r_iter),
        .atan         (w_atan),
        .nx           (w_nx),
        .ny           (w_ny),
        .nangle       (w_nangle)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_iter    <= '0;
            r_angle   <= '0;
            r_sat_q   <= 1'b0;
            r_cos     <= '0;
            r_sin     <= '0;
            r_out_sat <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_angle <= w_sat.angle;
                        r_sat_q <= w_sat.sat;
                        r_iter  <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (r_iter == LAST_ITER) begin
                        r_state <= StCapture;
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
                StCapture: begin
                    r_cos     <= w_nx;
                    r_sin     <= -w_ny;
                    r_out_sat <= r_sat_q;
                    r_iter    <= '0;
                    r_state   <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle) && !rst;
    assign bus.busy      = (r_state != StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.out_cos   = r_cos;
    assign bus.out_sin   = r_sin;
    assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed and random checks of cordic_sequencer against real-valued trig.
module tb_cordic_sequencer;

    localparam int unsigned ITER  = 24;
    localparam real         SCALE = 1073741824.0;
    localparam real         TOL   = 128.0;
    localparam logic signed [31:0] HP  = 32'sh6487ED51;
    localparam logic signed [31:0] NHP = -32'sh6487ED51;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    cordic_sequencer_if bus ();

    cordic_sequencer #(.ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input real exp);
        real diff;
        diff = real'($signed(obs)) - exp;
        if (diff < 0.0) diff = -diff;
        n_cmp++;
        assert (diff <= TOL) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0.1f (tolerance %0.0f)", tag,
                   $signed(obs), exp, TOL);
        end
    endtask

    function automatic logic signed [31:0] clamp(input logic signed [31:0] a);
        if (a > HP)  return HP;
        if (a < NHP) return NHP;
        return a;
    endfunction

    // Full request: accept, measure latency, check result, optional stall, release
    task automatic do_req(input string tag, input logic [31:0] angle, input int hold);
        logic signed [31:0] ca;
        real                rad;
        real                ec;
        real                es;
        logic               esat;
        int                 lat;
        ca   = clamp($signed(angle));
        esat = (ca != $signed(angle));
        rad  = real'(ca) / SCALE;
        ec   = $cos(rad) * SCALE;
        es   = $sin(rad) * SCALE;

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_angle = angle;
        chk_word({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_angle = $urandom();
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk_word({tag, " latency"}, 32'(lat), 32'(ITER + 1));
        chk_near({tag, " cos"}, bus.out_cos, ec);
        chk_near({tag, " sin"}, bus.out_sin, es);
        chk_word({tag, " sat"}, 32'(bus.out_sat), 32'(esat));

        for (int k = 0; k < hold; k++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = k[0];
            bus.in_angle  = $urandom();
            @(negedge clk);
            chk_word({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            chk_word({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            chk_near({tag, " hold cos"}, bus.out_cos, ec);
            chk_near({tag, " hold sin"}, bus.out_sin, es);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk_word({tag, " post in_ready"}, 32'(bus.in_ready), 32'd1);
        chk_word({tag, " post out_valid"}, 32'(bus.out_valid), 32'd0);
        chk_word({tag, " post busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_word("reset busy", 32'(bus.busy), 32'd0);
        chk_word("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk_word("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk_word("reset out_cos", bus.out_cos, 32'd0);
        chk_word("reset out_sin", bus.out_sin, 32'd0);
        chk_word("reset out_sat", 32'(bus.out_sat), 32'd0);
        rst = 1'b0;
        #1;
        chk_word("release in_ready", 32'(bus.in_ready), 32'd1);

        do_req("zero", 32'h00000000, 0);
        do_req("pi6", 32'h2182A470, 0);
        do_req("mpi4", 32'hCDBC0957, 0);
        do_req("clamp_pos", 32'h7FFFFFFF, 0);
        do_req("clamp_neg", 32'h80000000, 0);
        do_req("stall", 32'h1234ABCD, 10);

        for (int n = 0; n < 6; n++) begin
            do_req($sformatf("rand%0d", n), $urandom(), n % 3);
        end

        // Reset in the middle of RUN, at iteration 10
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_angle = 32'h2182A470;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk_word("midrun busy before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_word("midrun busy", 32'(bus.busy), 32'd0);
        chk_word("midrun out_valid", 32'(bus.out_valid), 32'd0);
        chk_word("midrun in_ready", 32'(bus.in_ready), 32'd0);
        chk_word("midrun out_cos", bus.out_cos, 32'd0);
        chk_word("midrun out_sat", 32'(bus.out_sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_word("midrun release in_ready", 32'(bus.in_ready), 32'd1);
        do_req("after_rst_pi6", 32'h2182A470, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
